// File: rtl/dot_prod_pkg.sv
// Shared definitions for the complex dot-product controller: FSM encoding and
// the full-precision accumulator width rule.
package dot_prod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  // DRAIN ends on the third edge after the final accept.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  function automatic int acc_width(input int xi_w, input int xq_w,
                                   input int yi_w, input int yq_w,
                                   input int len);
    int a;
    int b;
    a = xi_w + yi_w;
    b = xq_w + yq_w;
    return ((a > b) ? a : b) + 1 + $clog2(len);
  endfunction

endpackage

// File: rtl/cpx_multiply_conj.sv
// One-cycle registered partial products of x * conj(y); the cross-term sums
// are formed by the consumer so the product register stays a pure stage.
module cpx_multiply_conj #(
  parameter int xi_bits = 8,
  parameter int xq_bits = 8,
  parameter int yi_bits = 8,
  parameter int yq_bits = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vld_i,
  input  logic [xi_bits-1:0]         xi_i,
  input  logic [xq_bits-1:0]         xq_i,
  input  logic [yi_bits-1:0]         yi_i,
  input  logic [yq_bits-1:0]         yq_i,
  output logic                       vld_o,
  output logic [xi_bits+yi_bits-1:0] p_ii_o,
  output logic [xq_bits+yq_bits-1:0] p_qq_o,
  output logic [xq_bits+yi_bits-1:0] p_qi_o,
  output logic [xi_bits+yq_bits-1:0] p_iq_o
);

  logic                                vld_q;
  logic signed [xi_bits+yi_bits-1:0]   p_ii_q, p_ii_d;
  logic signed [xq_bits+yq_bits-1:0]   p_qq_q, p_qq_d;
  logic signed [xq_bits+yi_bits-1:0]   p_qi_q, p_qi_d;
  logic signed [xi_bits+yq_bits-1:0]   p_iq_q, p_iq_d;

  always_comb begin
    p_ii_d = $signed(xi_i) * $signed(yi_i);
    p_qq_d = $signed(xq_i) * $signed(yq_i);
    p_qi_d = $signed(xq_i) * $signed(yi_i);
    p_iq_d = $signed(xi_i) * $signed(yq_i);
  end

  // Product stage; data only loads on an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      p_ii_q <= '0;
      p_qq_q <= '0;
      p_qi_q <= '0;
      p_iq_q <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        p_ii_q <= p_ii_d;
        p_qq_q <= p_qq_d;
        p_qi_q <= p_qi_d;
        p_iq_q <= p_iq_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign p_ii_o = p_ii_q;
  assign p_qq_o = p_qq_q;
  assign p_qi_o = p_qi_q;
  assign p_iq_o = p_iq_q;

endmodule

// File: rtl/dot_prod_ctrl.sv
// Complex dot product controller: accepts length paired x/y samples, accumulates
// x*conj(y) at full precision and presents the truncated result until taken.
module dot_prod_ctrl
  import dot_prod_pkg::*;
#(
  parameter int xi_bits = 8,
  parameter int xq_bits = 8,
  parameter int yi_bits = 8,
  parameter int yq_bits = 8,
  parameter int length  = 4,
  parameter int i_bits  = 19,
  parameter int q_bits  = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_axis_x_tvalid,
  input  logic [xi_bits-1:0] xi,
  input  logic [xq_bits-1:0] xq,
  input  logic               m_axis_y_tvalid,
  input  logic [yi_bits-1:0] yi,
  input  logic [yq_bits-1:0] yq,
  output logic               m_axis_x_tready,
  output logic               m_axis_y_tready,
  output logic               s_axis_tvalid,
  output logic [i_bits-1:0]  i,
  output logic [q_bits-1:0]  q,
  input  logic               m_axis_product_tready
);

  localparam int ACC_W = acc_width(xi_bits, xq_bits, yi_bits, yq_bits, length);
  localparam int CNT_W = (length > 1) ? $clog2(length) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(length - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               drain_q, drain_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic                     tready_q, tready_d;
  logic                     tvalid_q, tvalid_d;
  logic [i_bits-1:0]        res_i_q, res_i_d;
  logic [q_bits-1:0]        res_q_q, res_q_d;

  logic                         accept_s;
  logic                         prod_vld_s;
  logic [xi_bits+yi_bits-1:0]   p_ii_s;
  logic [xq_bits+yq_bits-1:0]   p_qq_s;
  logic [xq_bits+yi_bits-1:0]   p_qi_s;
  logic [xi_bits+yq_bits-1:0]   p_iq_s;
  logic signed [ACC_W-1:0]      re_s, im_s;

  assign accept_s = tready_q & m_axis_x_tvalid & m_axis_y_tvalid;

  cpx_multiply_conj #(
    .xi_bits (xi_bits),
    .xq_bits (xq_bits),
    .yi_bits (yi_bits),
    .yq_bits (yq_bits)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (accept_s),
    .xi_i   (xi),
    .xq_i   (xq),
    .yi_i   (yi),
    .yq_i   (yq),
    .vld_o  (prod_vld_s),
    .p_ii_o (p_ii_s),
    .p_qq_o (p_qq_s),
    .p_qi_o (p_qi_s),
    .p_iq_o (p_iq_s)
  );

  assign re_s = ACC_W'($signed(p_ii_s)) + ACC_W'($signed(p_qq_s));
  assign im_s = ACC_W'($signed(p_qi_s)) - ACC_W'($signed(p_iq_s));

  // Next-state, counter, accumulator and output-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    tvalid_d = tvalid_q;
    res_i_d  = res_i_q;
    res_q_d  = res_q_q;

    if (prod_vld_s) begin
      acc_re_d = acc_re_q + re_s;
      acc_im_d = acc_im_q + im_s;
    end else begin
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
    end

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept_s) begin
          // A new vector starts from zero; its first product lands next edge.
          if (state_q == ST_IDLE) begin
            acc_re_d = '0;
            acc_im_d = '0;
          end else begin
            acc_re_d = acc_re_d;
            acc_im_d = acc_im_d;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
            drain_d = 2'd0;
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d  = ST_OUTPUT;
          tvalid_d = 1'b1;
          res_i_d  = acc_re_q[ACC_W-1 -: i_bits];
          res_q_d  = acc_im_q[ACC_W-1 -: q_bits];
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_OUTPUT: begin
        if (m_axis_product_tready) begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          acc_re_d = '0;
          acc_im_d = '0;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        tvalid_d = 1'b0;
      end
    endcase

    tready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      drain_q  <= 2'd0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      res_i_q  <= '0;
      res_q_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      res_i_q  <= res_i_d;
      res_q_q  <= res_q_d;
    end
  end

  assign m_axis_x_tready = tready_q;
  assign m_axis_y_tready = tready_q;
  assign s_axis_tvalid   = tvalid_q;
  assign i               = res_i_q;
  assign q               = res_q_q;

endmodule

// File: tb/tb_dot_prod_ctrl.sv
// Directed and randomized bench for dot_prod_ctrl (length=4, 8-bit inputs)
// against an arithmetic reference computed from the sample arrays.
module tb_dot_prod_ctrl;

  localparam int LEN    = 4;
  localparam int ACC_W  = 8 + 8 + 1 + 2;
  localparam int I_BITS = 19;
  localparam int Q_BITS = 19;

  logic clk = 1'b0;
  logic rst_n;
  logic xv, yv, prod_rdy;
  logic [7:0] xi_d, xq_d, yi_d, yq_d;
  logic x_rdy, y_rdy, tvalid;
  logic signed [I_BITS-1:0] i_w;
  logic signed [Q_BITS-1:0] q_w;

  int n_assert = 0;
  int n_fail   = 0;
  int vxi[LEN], vxq[LEN], vyi[LEN], vyq[LEN];
  longint exp_i_g, exp_q_g;

  always #5 clk = ~clk;

  dot_prod_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .m_axis_x_tvalid       (xv),
    .xi                    (xi_d),
    .xq                    (xq_d),
    .m_axis_y_tvalid       (yv),
    .yi                    (yi_d),
    .yq                    (yq_d),
    .m_axis_x_tready       (x_rdy),
    .m_axis_y_tready       (y_rdy),
    .s_axis_tvalid         (tvalid),
    .i                     (i_w),
    .q                     (q_w),
    .m_axis_product_tready (prod_rdy)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_uniform(input int a, input int b, input int c, input int d);
    for (int k = 0; k < LEN; k++) begin
      vxi[k] = a; vxq[k] = b; vyi[k] = c; vyq[k] = d;
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < LEN; k++) begin
      vxi[k] = int'($urandom_range(255)) - 128;
      vxq[k] = int'($urandom_range(255)) - 128;
      vyi[k] = int'($urandom_range(255)) - 128;
      vyq[k] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic push(input int k);
    @(negedge clk);
    xi_d = 8'(vxi[k]); xq_d = 8'(vxq[k]);
    yi_d = 8'(vyi[k]); yq_d = 8'(vyq[k]);
    xv = 1'b1; yv = 1'b1;
    check("tready_before_accept", x_rdy, 1);
    check("tready_x_eq_y", x_rdy, y_rdy);
    @(posedge clk);
    #1;
    xv = 1'b0; yv = 1'b0;
  endtask

  // Called right after the final accept edge; measures latency and checks result.
  task automatic expect_result(input string tag);
    longint ei, eq;
    int lat;
    ei = 0; eq = 0;
    for (int k = 0; k < LEN; k++) begin
      ei += longint'(vxi[k]) * vyi[k] + longint'(vxq[k]) * vyq[k];
      eq += longint'(vxq[k]) * vyi[k] - longint'(vxi[k]) * vyq[k];
    end
    exp_i_g = ei >>> (ACC_W - I_BITS);
    exp_q_g = eq >>> (ACC_W - Q_BITS);
    check({tag, "_drain_tready"}, x_rdy, 0);
    check({tag, "_no_early_valid"}, tvalid, 0);
    lat = 0;
    while (tvalid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_i"}, i_w, exp_i_g);
    check({tag, "_q"}, q_w, exp_q_g);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    prod_rdy = 1'b1;
    @(posedge clk);
    #1;
    prod_rdy = 1'b0;
    check({tag, "_valid_drop"}, tvalid, 0);
    check({tag, "_tready_back"}, x_rdy, 1);
  endtask

  task automatic run_vec(input string tag);
    for (int k = 0; k < LEN; k++) push(k);
    expect_result(tag);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; xv = 1'b0; yv = 1'b0; prod_rdy = 1'b0;
    xi_d = 8'd0; xq_d = 8'd0; yi_d = 8'd0; yq_d = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", x_rdy, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_i", i_w, 0);
    check("rst_q", q_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_tready", x_rdy, 1);

    set_uniform(1, 0, 1, 0);        run_vec("unit");
    set_uniform(3, 4, 3, 4);        run_vec("mag25");
    set_uniform(0, 1, 1, 0);        run_vec("quad");
    set_uniform(-128, -128, -128, -128); run_vec("maxneg");

    // y_tvalid gap mid-vector: gap data would change the sum if accepted.
    set_uniform(1, 0, 1, 0);
    push(0); push(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      xi_d = 8'd5; xq_d = 8'd0; yi_d = 8'd5; yq_d = 8'd0;
      xv = 1'b1; yv = 1'b0;
      check("gap_tready", x_rdy, 1);
    end
    @(negedge clk);
    xv = 1'b0;
    push(2); push(3);
    expect_result("gap");
    handshake("gap");

    // Downstream stall for 5 cycles, then back-to-back next vector.
    set_uniform(3, 4, 3, 4);
    for (int k = 0; k < LEN; k++) push(k);
    expect_result("stall");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_i", i_w, exp_i_g);
      check("stall_q", q_w, exp_q_g);
      check("stall_valid", tvalid, 1);
      check("stall_tready", x_rdy, 0);
    end
    handshake("stall");
    set_uniform(0, 1, 1, 0);        run_vec("after_stall");

    // Reset mid-ACCUM discards the partial sum.
    set_uniform(7, -3, 2, 5);
    push(0); push(1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tready", x_rdy, 0);
    check("rst_mid_tvalid", tvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_first_tready", x_rdy, 1);
    set_uniform(1, 0, 1, 0);        run_vec("post_rst_accum");

    // Reset in DRAIN: no stale result may surface.
    set_random();
    for (int k = 0; k < LEN; k++) push(k);
    rst_n = 1'b0;
    #1;
    check("rst_drain_i", i_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("rst_drain_no_valid", tvalid, 0);
    end

    // Reset in OUTPUT clears the presented result.
    set_random();
    for (int k = 0; k < LEN; k++) push(k);
    expect_result("pre_rst_out");
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_tvalid", tvalid, 0);
    check("rst_out_i", i_w, 0);
    check("rst_out_q", q_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    for (int r = 0; r < 4; r++) begin
      set_random();
      run_vec("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_prod_ctrl.md
DOT_PROD_CTRL -- requirements
Module: dot_prod_ctrl

Interface
REQ-001 SHALL have parameter xi_bits, default 8, the signed width of the x in-phase sample.
REQ-002 SHALL have parameters xq_bits, yi_bits and yq_bits, default 8 each, the signed widths of x quadrature, y in-phase and y quadrature.
REQ-003 SHALL have parameter length, default 4, the samples per dot product (1 or more).
REQ-004 SHALL have parameters i_bits and q_bits, default 19 each, the output widths; each is at most the accumulator width.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 m_axis_x_tvalid  in  1  xi/xq valid.
REQ-008 xi, xq  in  xi_bits, xq_bits  signed x sample.
REQ-009 m_axis_y_tvalid  in  1  yi/yq valid.
REQ-010 yi, yq  in  yi_bits, yq_bits  signed y sample.
REQ-011 m_axis_x_tready, m_axis_y_tready  out  1  sample accept; the two are always equal.
REQ-012 s_axis_tvalid  out  1  result valid.
REQ-013 i, q  out  i_bits, q_bits  signed result.
REQ-014 m_axis_product_tready  in  1  downstream accepts the result.

Function
REQ-015 SHALL compute, over length samples, i = sum(xi*yi + xq*yq) and q = sum(xq*yi - xi*yq), which is x times conj(y).
REQ-016 Accumulator width SHALL be max(xi_bits+yi_bits, xq_bits+yq_bits)+1+clog2(length); it SHALL be full precision with no overflow.
REQ-017 i/q SHALL carry the top i_bits/q_bits of the accumulator (truncation, no rounding).
REQ-018 The FSM SHALL have four states: IDLE, ACCUM, DRAIN, OUTPUT.
REQ-019 IDLE->ACCUM and ACCUM->ACCUM SHALL occur on a sample accept: tready=1 and both tvalids=1 on the same edge.
REQ-020 tready SHALL be 1 in IDLE and ACCUM and 0 in DRAIN and OUTPUT; a single tvalid alone SHALL NOT be accepted.
REQ-021 The sample counter SHALL increment per accept and hold on gaps; accepting sample length-1 SHALL go to DRAIN and wrap the counter to 0.
REQ-022 The multiply pipeline SHALL be 2 register stages: products, then cross-term sum into the accumulator.
REQ-023 s_axis_tvalid SHALL rise on the 3rd rising edge after the edge that accepted the last sample (DRAIN->OUTPUT).
REQ-024 In OUTPUT, i/q/s_axis_tvalid SHALL hold stable until m_axis_product_tready=1.
REQ-025 On the handshake the block SHALL go to IDLE, clear the accumulator and drop s_axis_tvalid on the next edge.
REQ-026 With length=1 the block SHALL go from IDLE directly to DRAIN on the single accept.
REQ-027 The accumulator SHALL clear on entry to ACCUM, so there is no carry-over between vectors.

Reset
REQ-028 While rst_n=0: state IDLE, counter 0, pipeline and accumulator 0, i=q=0, s_axis_tvalid=0, tready=0.
REQ-029 On the first edge after deassertion, tready SHALL be 1.
REQ-030 Reset mid-ACCUM, DRAIN or OUTPUT SHALL discard the partial result; no stale value SHALL appear afterwards.

Structure
REQ-031 The FSM state encoding and the accumulator-width function SHALL live in shared package dot_prod_pkg.
REQ-032 The complex product SHALL be one sub-module, cpx_multiply_conj: 1-cycle registered x*conj(y).
REQ-033 The FSM, counter and accumulator SHALL stay in dot_prod_ctrl.

Verification (length=4, 8-bit inputs)
REQ-034 x=(1,0), y=(1,0) for 4 samples -> i=4, q=0; s_axis_tvalid rises 3 edges after the 4th accept.
REQ-035 x=(3,4), y=(3,4) x4 -> i=100, q=0; x=(0,1), y=(1,0) x4 -> i=0, q=4.
REQ-036 m_axis_y_tvalid low for 3 cycles mid-vector with x_tvalid high -> no accept, counter holds, result i=4, q=0.
REQ-037 m_axis_product_tready low 5 cycles in OUTPUT -> i/q and tvalid stable, tready=0; next vector accepted one edge after the handshake.
REQ-038 rst_n pulsed after 2 accepts, then a full (1,0)/(1,0) vector -> i=4, q=0.
REQ-039 x=(-128,-128), y=(-128,-128) x4 -> i=131072, q=0 with no overflow, checking the REQ-016 width.
